fiat_25519_carry_square_udiv_64ns_32ns_seq: RTL and testbench

//   Sequential unsigned radix-2 restoring divider. Inverse of the 33ns x 32ns -> 64 product core.

---
 rtl/fiat_25519_carry_square_udiv_64ns_32ns_seq_if.sv | 25 ++
 rtl/fiat_25519_carry_square_udiv_64ns_32ns_seq.sv | 125 ++++++++++++
 tb/tb_fiat_25519_carry_square_udiv_64ns_32ns_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fiat_25519_carry_square_udiv_64ns_32ns_seq_if.sv
// Start/done handshake and operand/result bundle for the sequential 64/32 unsigned divider.
// The requester drives start and operands; the divider returns status and results.
interface fiat_25519_carry_square_udiv_64ns_32ns_seq_if #(
    parameter int DIVIDEND_W = 64,
    parameter int DIVISOR_W  = 32
);
    logic                  ap_start;
    logic [DIVIDEND_W-1:0] din0;
    logic [DIVISOR_W-1:0]  din1;
    logic                  ap_idle;
    logic                  ap_done;
    logic                  div_zero;
    logic [DIVIDEND_W-1:0] quot;
    logic [DIVISOR_W-1:0]  rem;

    modport master (
        output ap_start, din0, din1,
        input  ap_idle, ap_done, div_zero, quot, rem
    );

    modport slave (
        input  ap_start, din0, din1,
        output ap_idle, ap_done, div_zero, quot, rem
    );
endinterface

// File: rtl/fiat_25519_carry_square_udiv_64ns_32ns_seq.sv
// Radix-2 restoring divider: one quotient bit per clock, MSB first, with a
// start/done handshake and a divide-by-zero fast path.
module fiat_25519_carry_square_udiv_64ns_32ns_seq #(
    parameter int ID         = 1,
    parameter int DIVIDEND_W = 64,
    parameter int DIVISOR_W  = 32
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    fiat_25519_carry_square_udiv_64ns_32ns_seq_if.slave bus
);
    localparam int N     = DIVIDEND_W;
    localparam int M     = DIVISOR_W;
    localparam int CNT_W = $clog2(N + 1);

    // The instance tag and the M <= N relation carry no logic.
    if (M > N || ID < 0) begin : g_bad_params
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [M-1:0]     dvs_q, dvs_d;
    logic [M-1:0]     p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     quot_q, quot_d;
    logic [M-1:0]     rem_q, rem_d;
    logic             dz_q, dz_d;

    // Quotient bits shift into the vacated low end of the dividend register,
    // so after N iterations it holds the full quotient.
    logic [M:0]   p_shift;
    logic         ge;
    logic [M-1:0] p_sub;
    logic [M-1:0] p_new;
    logic [N-1:0] q_shift;

    // The partial remainder is always below the divisor, so the difference
    // fits in M bits even though the shifted value needs M+1.
    assign p_shift = {p_q, dvd_q[N-1]};
    assign ge      = (p_shift >= {1'b0, dvs_q});
    assign p_sub   = p_shift[M-1:0] - dvs_q;
    assign p_new   = ge ? p_sub : p_shift[M-1:0];
    assign q_shift = {dvd_q[N-2:0], ge};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.ap_start) begin
                    dvd_d = bus.din0;
                    dvs_d = bus.din1;
                    p_d   = '0;
                    cnt_d = CNT_W'(N);
                    dz_d  = 1'b0;
                    if (bus.din1 == '0) begin
                        quot_d  = '1;
                        rem_d   = bus.din0[M-1:0];
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                dvd_d = q_shift;
                p_d   = p_new;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quot_d  = q_shift;
                    rem_d   = p_new;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.ap_idle  = (state_q == S_IDLE);
    assign bus.ap_done  = (state_q == S_DONE);
    assign bus.div_zero = dz_q;
    assign bus.quot     = quot_q;
    assign bus.rem      = rem_q;
endmodule

// File: tb/tb_fiat_25519_carry_square_udiv_64ns_32ns_seq.sv
// Directed-vector bench for the sequential 64/32 divider: table of operands with
// hand-computed results plus sequences for hold-over, held start and mid-op reset.
module tb_fiat_25519_carry_square_udiv_64ns_32ns_seq;
    localparam int N = 64;
    localparam int M = 32;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    fiat_25519_carry_square_udiv_64ns_32ns_seq_if #(.DIVIDEND_W(N), .DIVISOR_W(M)) bus ();

    fiat_25519_carry_square_udiv_64ns_32ns_seq #(
        .ID(1), .DIVIDEND_W(N), .DIVISOR_W(M)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] a;
        logic [31:0] b;
        logic [63:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[$];

    logic [63:0] held_q[$];
    logic [31:0] held_r[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [63:0] a, input logic [31:0] b,
                           input logic [63:0] q, input logic [31:0] r, input logic dz);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz;
        vecs.push_back(v);
    endtask

    // Start one op with a 1-cycle pulse, scramble the operands after accept,
    // and return at the negedge where ap_done is seen (lat = -1 on timeout).
    task automatic run_op(input logic [63:0] a, input logic [31:0] b,
                          output logic [63:0] q, output logic [31:0] r,
                          output logic dz, output int lat);
        int edges;
        bit seen;
        @(negedge ap_clk);
        chk("idle_before_start", 64'(bus.ap_idle), 64'd1);
        bus.din0     = a;
        bus.din1     = b;
        bus.ap_start = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 200) begin
            @(posedge ap_clk);
            edges++;
            @(negedge ap_clk);
            bus.ap_start = 1'b0;
            bus.din0     = ~a;
            bus.din1     = b ^ 32'h5A5A_0001;
            if (bus.ap_done) seen = 1'b1;
        end
        lat = seen ? edges : -1;
        if (seen) chk("done_not_idle", 64'(bus.ap_idle), 64'd0);
        q  = bus.quot;
        r  = bus.rem;
        dz = bus.div_zero;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge ap_clk);
            if (bus.ap_done) seen = 1'b1;
        end
    endtask

    task automatic held_drive();
        logic [63:0] a;
        logic [31:0] b;
        a = {$urandom, $urandom};
        b = $urandom | 32'h1;
        bus.din0 = a;
        bus.din1 = b;
        if (bus.ap_idle && bus.ap_start) begin
            held_q.push_back(a / 64'(b));
            held_r.push_back(32'(a % 64'(b)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        bit          seen;
        int          results, cyc, last_done, done_cnt;
        bit          prev_done;
        logic [63:0] hq;
        logic [31:0] hr;

        bus.ap_start = 1'b0;
        bus.din0     = '0;
        bus.din1     = '0;

        // Reset values while ap_rst_n is held low.
        #2;
        chk("rst_idle", 64'(bus.ap_idle), 64'd1);
        chk("rst_done", 64'(bus.ap_done), 64'd0);
        chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
        chk("rst_quot", bus.quot, 64'd0);
        chk("rst_rem", 64'(bus.rem), 64'd0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;

        add_vec(64'd100, 32'd7, 64'd14, 32'd2, 1'b0);
        // (2^33-1)*(2^32-1) wraps to this 64-bit value.
        add_vec(64'hFFFF_FFFD_0000_0001, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFD, 32'hFFFF_FFFE, 1'b0);
        add_vec(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0001_0000_0001, 32'd0, 1'b0);
        add_vec(64'hDEAD_BEEF_1234_5678, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1234_5678, 1'b1);
        add_vec(64'd5, 32'hFFFF_FFFF, 64'd0, 32'd5, 1'b0);
        add_vec(64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b0);
        add_vec(64'hFFFF_FFFF_FFFF_FFFF, 32'h8000_0000, 64'h0000_0001_FFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        add_vec(64'd1000, 32'd1000, 64'd1, 32'd0, 1'b0);
        add_vec(64'd7, 32'd100, 64'd0, 32'd7, 1'b0);
        add_vec(64'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b1);
        // Round trips: a*b + r with r < b, which fits in 64 bits for 32-bit a and b.
        for (int i = 0; i < 12; i++) begin
            logic [63:0] a64, b64, r64;
            a64 = 64'($urandom);
            b64 = 64'($urandom | 32'h1);
            r64 = 64'($urandom) % b64;
            add_vec(a64 * b64 + r64, 32'(b64), a64, 32'(r64), 1'b0);
        end

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, q, r, dz, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), vecs[i].dz ? 64'd1 : 64'd65);
            chk($sformatf("v%0d_quot", i), q, vecs[i].q);
            chk($sformatf("v%0d_rem", i), 64'(r), 64'(vecs[i].r));
            chk($sformatf("v%0d_div_zero", i), 64'(dz), 64'(vecs[i].dz));
            @(negedge ap_clk);
            chk($sformatf("v%0d_done_pulse", i), 64'(bus.ap_done), 64'd0);
            chk($sformatf("v%0d_hold_quot", i), bus.quot, vecs[i].q);
            $display("vec %0d: %h / %h -> quot=%h rem=%h dz=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, q, r, dz, lat);
        end

        // Results from a divide-by-zero survive the next accept; only div_zero clears.
        run_op(64'hDEAD_BEEF_1234_5678, 32'd0, q, r, dz, lat);
        chk("hold_dz_latency", 64'(lat), 64'd1);
        @(negedge ap_clk);
        bus.din0     = 64'd100;
        bus.din1     = 32'd7;
        bus.ap_start = 1'b1;
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        chk("hold_div_zero_cleared", 64'(bus.div_zero), 64'd0);
        chk("hold_quot_kept", bus.quot, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("hold_rem_kept", 64'(bus.rem), 64'h1234_5678);
        chk("hold_running_not_idle", 64'(bus.ap_idle), 64'd0);
        wait_done(100, seen);
        chk("hold_done_seen", 64'(seen), 64'd1);
        chk("hold_quot", bus.quot, 64'd14);
        chk("hold_rem", 64'(bus.rem), 64'd2);
        $display("hold-over: 100/7 after div-zero -> quot=%0d rem=%0d", bus.quot, bus.rem);

        // ap_start held high with operands changing every cycle.
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        held_drive();
        results   = 0;
        cyc       = 0;
        last_done = -1;
        prev_done = 1'b0;
        while (results < 3 && cyc < 400) begin
            @(negedge ap_clk);
            cyc++;
            if (bus.ap_done) begin
                chk("held_single_pulse", 64'(prev_done), 64'd0);
                chk("held_done_not_idle", 64'(bus.ap_idle), 64'd0);
                if (held_q.size() == 0) begin
                    chk("held_expected_queue", 64'd0, 64'd1);
                end else begin
                    hq = held_q.pop_front();
                    hr = held_r.pop_front();
                    chk($sformatf("held%0d_quot", results), bus.quot, hq);
                    chk($sformatf("held%0d_rem", results), 64'(bus.rem), 64'(hr));
                end
                if (last_done >= 0) chk("held_interval", 64'(cyc - last_done), 64'd66);
                $display("held result %0d at cycle %0d: quot=%h rem=%h", results, cyc, bus.quot, bus.rem);
                last_done = cyc;
                results++;
            end
            prev_done = bus.ap_done;
            if (results == 3) bus.ap_start = 1'b0;
            held_drive();
        end
        chk("held_results", 64'(results), 64'd3);
        bus.ap_start = 1'b0;
        @(negedge ap_clk);
        chk("held_no_extra_accept", 64'(bus.ap_idle), 64'd1);

        // Reset at iteration 30 of a running op.
        @(negedge ap_clk);
        bus.din0     = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.din1     = 32'd3;
        bus.ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        repeat (29) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        chk("abort_quot", bus.quot, 64'd0);
        chk("abort_rem", 64'(bus.rem), 64'd0);
        chk("abort_div_zero", 64'(bus.div_zero), 64'd0);
        chk("abort_idle", 64'(bus.ap_idle), 64'd1);
        chk("abort_done", 64'(bus.ap_done), 64'd0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        done_cnt = 0;
        repeat (80) begin
            @(negedge ap_clk);
            if (bus.ap_done) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        run_op(64'd9, 32'd3, q, r, dz, lat);
        chk("after_abort_latency", 64'(lat), 64'd65);
        chk("after_abort_quot", q, 64'd3);
        chk("after_abort_rem", 64'(r), 64'd0);
        $display("after abort: 9/3 -> quot=%0d rem=%0d", q, r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
